// File: rtl/lock_pkg.sv
// lock_pkg: shared direction, button and player-state types for the digital lock
package lock_pkg;
  typedef enum logic [1:0] {DIR_W, DIR_E, DIR_S, DIR_N} dir_t;
  typedef enum logic [2:0] {ST_IDLE, ST_PULSE, ST_GAP, ST_WAIT, ST_DONE} player_state_t;
  localparam logic [3:0] BTN_W = 4'b0001;
  localparam logic [3:0] BTN_E = 4'b0010;
  localparam logic [3:0] BTN_S = 4'b0100;
  localparam logic [3:0] BTN_N = 4'b1000;
  function automatic logic [3:0] dir_to_btn(input dir_t d);
    return d == DIR_W ? BTN_W : d == DIR_E ? BTN_E : d == DIR_S ? BTN_S : BTN_N;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/lock_code_player_if.sv
// lock_code_player_if: control, status and button signals between a controller and the player
interface lock_code_player_if #(parameter int CODE_LEN = 4);
  localparam int SW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  logic start;
  logic abort;
  logic [2*CODE_LEN-1:0] code;
  logic unlocked;
  logic [3:0] btn;
  logic busy;
  logic [SW-1:0] sym_idx;
  logic done;
  logic pass;
  modport master(output start, abort, code, unlocked, input btn, busy, sym_idx, done, pass);
  modport slave(input start, abort, code, unlocked, output btn, busy, sym_idx, done, pass);
endinterface

// File: rtl/lock_phase_timer.sv
// lock_phase_timer: loadable saturating down-counter flagging the last cycle of a phase
module lock_phase_timer #(parameter int W = 5) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign tc_o = cnt_q <= W'(1);
endmodule

// File: rtl/lock_code_player.sv
// lock_code_player: replays a stored N/S/E/W code as one-hot button pulses and reports unlock result
module lock_code_player import lock_pkg::*; #(
  parameter int CODE_LEN     = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 4,
  parameter int RESP_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  lock_code_player_if.slave bus
);
  localparam int SW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  localparam int TW = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, RESP_TIMEOUT) + 1);
  localparam logic [SW-1:0] LAST = SW'(CODE_LEN - 1);
  player_state_t state_q, state_d;
  logic [2*CODE_LEN-1:0] code_q, code_d;
  logic [SW-1:0] idx_q, idx_d;
  logic pass_q, pass_d;
  logic [3:0] btn_q, btn_d;
  logic busy_q, done_q;
  logic ld, tc, en;
  logic [TW-1:0] ld_val;
  lock_phase_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load_i(ld), .val_i(ld_val), .en_i(en), .tc_o(tc)
  );
  assign en = state_q == ST_PULSE || state_q == ST_GAP || state_q == ST_WAIT;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    ld      = 1'b0;
    ld_val  = '0;
    if (state_q == ST_IDLE) begin
      if (bus.start && !bus.abort) begin
        state_d = ST_PULSE;
        code_d  = bus.code;
        idx_d   = '0;
        pass_d  = 1'b0;
        ld      = 1'b1;
        ld_val  = TW'(PULSE_CYCLES);
      end
    end else if (bus.abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PULSE: if (tc) begin
          state_d = ST_GAP;
          ld      = 1'b1;
          ld_val  = TW'(GAP_CYCLES);
        end
        ST_GAP: if (tc) begin
          state_d = idx_q == LAST ? ST_WAIT : ST_PULSE;
          idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
          ld      = 1'b1;
          ld_val  = idx_q == LAST ? TW'(RESP_TIMEOUT) : TW'(PULSE_CYCLES);
        end
        ST_WAIT: if (bus.unlocked || tc) begin
          state_d = ST_DONE;
          pass_d  = bus.unlocked;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // Outputs are registered from next-state so they line up with the state they describe
  assign btn_d = state_d == ST_PULSE ? dir_to_btn(dir_t'(code_d[{idx_d, 1'b0} +: 2])) : 4'b0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
      btn_q   <= 4'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      btn_q   <= btn_d;
      busy_q  <= state_d != ST_IDLE;
      done_q  <= state_d == ST_DONE;
    end
  end
  assign bus.btn     = btn_q;
  assign bus.busy    = busy_q;
  assign bus.sym_idx = idx_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
endmodule

// File: tb/tb_lock_code_player.sv
// tb_lock_code_player: directed self-checking bench for lock_code_player at default parameters
module tb_lock_code_player;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int mis = 0;
  lock_code_player_if #(.CODE_LEN(4)) bus ();
  lock_code_player dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask
  // seq holds the expected one-hot buttons, symbol 0 in the low nibble; ends on first WAIT cycle
  task automatic play(input logic [15:0] seq);
    for (int i = 0; i < 4; i++) begin
      chk("pulse_btn", bus.btn, seq[4*i +: 4]);
      chk("pulse_idx", bus.sym_idx, i);
      chk("pulse_busy", bus.busy, 1);
      chk("pulse_done", bus.done, 0);
      repeat (4) begin
        tick();
        chk("gap_btn", bus.btn, 0);
      end
      tick();
    end
    chk("wait_btn", bus.btn, 0);
    chk("wait_busy", bus.busy, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.code = 8'h00;
    bus.unlocked = 1'b0;
    tick();
    tick();
    chk("rst_btn", bus.btn, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_idx", bus.sym_idx, 0);
    rst_n = 1'b1;
    // S,W,E,W with unlock on the third WAIT cycle
    bus.code = 8'h12;
    bus.start = 1'b1;
    tick();
    play(16'h1214);
    tick();
    tick();
    bus.unlocked = 1'b1;
    tick();
    chk("t2_done", bus.done, 1);
    chk("t2_pass", bus.pass, 1);
    chk("t2_busy_done", bus.busy, 1);
    bus.unlocked = 1'b0;
    tick();
    chk("t2_done_off", bus.done, 0);
    chk("t2_busy_off", bus.busy, 0);
    chk("t2_pass_hold", bus.pass, 1);
    // Timeout: done exactly 16 cycles after WAIT entry
    bus.start = 1'b1;
    tick();
    chk("t3_pass_clr", bus.pass, 0);
    play(16'h1214);
    for (int j = 0; j < 16; j++) begin
      chk("t3_wait_done", bus.done, 0);
      tick();
    end
    chk("t3_done", bus.done, 1);
    chk("t3_pass", bus.pass, 0);
    tick();
    chk("t3_busy_off", bus.busy, 0);
    // Abort during second gap
    bus.start = 1'b1;
    tick();
    chk("t4_p0", bus.btn, 4'b0100);
    repeat (4) tick();
    tick();
    chk("t4_p1", bus.btn, 4'b0001);
    chk("t4_idx1", bus.sym_idx, 1);
    tick();
    chk("t4_gap", bus.btn, 0);
    bus.abort = 1'b1;
    tick();
    chk("t4_ab_btn", bus.btn, 0);
    chk("t4_ab_busy", bus.busy, 0);
    chk("t4_ab_done", bus.done, 0);
    chk("t4_ab_pass", bus.pass, 0);
    tick();
    chk("t4_ab_done2", bus.done, 0);
    chk("t4_ab_busy2", bus.busy, 0);
    bus.start = 1'b1;
    tick();
    play(16'h1214);
    bus.unlocked = 1'b1;
    tick();
    chk("t4_done", bus.done, 1);
    chk("t4_pass", bus.pass, 1);
    bus.unlocked = 1'b0;
    tick();
    // start while busy with a different code is ignored
    bus.start = 1'b1;
    tick();
    bus.code = 8'hFF;
    bus.start = 1'b1;
    play(16'h1214);
    bus.unlocked = 1'b1;
    tick();
    chk("t5_done", bus.done, 1);
    chk("t5_pass", bus.pass, 1);
    bus.unlocked = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    chk("t5_sa_busy", bus.busy, 0);
    chk("t5_sa_btn", bus.btn, 0);
    tick();
    chk("t5_sa_busy2", bus.busy, 0);
    // E,E,W,W repeated symbols keep their gaps
    bus.code = 8'h05;
    bus.start = 1'b1;
    tick();
    play(16'h1122);
    bus.unlocked = 1'b1;
    tick();
    chk("t6_done", bus.done, 1);
    bus.unlocked = 1'b0;
    tick();
    // Reset in the middle of a pulse
    bus.start = 1'b1;
    tick();
    chk("t6_p0", bus.btn, 4'b0010);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_btn", bus.btn, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_idx", bus.sym_idx, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_post_btn", bus.btn, 0);
    chk("t6_post_busy", bus.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
